bluejay_line_tracker: RTL

- Control stage directly upstream of bluejay_data, in the fpga_clk domain.
- Tracks the fill level of the dc32 FIFO from write strobes and bluejay_data's get_next_word read strobes.
- Asserts line_of_data_available whenever at least one full SLM line is buffered.
- Counts consumed lines; at end of frame it performs the buffer-switch request/acknowledge handshake with the Bluejay SLM and issues buffer_switch_done.

---
 rtl/bluejay_pkg.sv | 31 +++
 rtl/bluejay_line_tracker_if.sv | 37 +++
 rtl/bluejay_occupancy_counter.sv | 61 ++++++
 rtl/bluejay_line_tracker.sv | 135 +++++++++++++
 4 files changed

// File: rtl/bluejay_pkg.sv
// bluejay_pkg
//   Shared definitions for the Bluejay SLM line tracker.
//   - bluejay_state_e : tracker FSM state encoding
//   - DEF_*           : default line/frame/FIFO geometry
//   - clog2           : width helper for counters
package bluejay_pkg;

    typedef enum logic [1:0] {
        ST_STREAM = 2'd0,
        ST_REQ    = 2'd1,
        ST_DONE   = 2'd2
    } bluejay_state_e;

    localparam int DEF_WORDS_PER_LINE  = 320;
    localparam int DEF_LINES_PER_FRAME = 1024;
    localparam int DEF_FIFO_DEPTH      = 1024;

    // Number of bits needed to represent 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bluejay_line_tracker_if.sv
// bluejay_line_tracker_if
//   Strobe/handshake bundle between the FIFO/SLM side and the line tracker.
//   - fifo_write             : word accepted into the dc32 FIFO
//   - get_next_word          : read strobe from bluejay_data
//   - slm_buffer_ack         : SLM buffer-switch acknowledge (level)
//   - line_of_data_available : at least one full line buffered
//   - update_request         : buffer-switch request to the SLM
//   - buffer_switch_done     : one-cycle pulse when the switch completes
//   master drives the strobes and ack; slave is the tracker.
interface bluejay_line_tracker_if;

    logic fifo_write;
    logic get_next_word;
    logic slm_buffer_ack;
    logic line_of_data_available;
    logic update_request;
    logic buffer_switch_done;

    modport master (
        output fifo_write,
        output get_next_word,
        output slm_buffer_ack,
        input  line_of_data_available,
        input  update_request,
        input  buffer_switch_done
    );

    modport slave (
        input  fifo_write,
        input  get_next_word,
        input  slm_buffer_ack,
        output line_of_data_available,
        output update_request,
        output buffer_switch_done
    );

endinterface

// File: rtl/bluejay_occupancy_counter.sv
// bluejay_occupancy_counter
//   Saturating up/down occupancy counter for the dc32 FIFO.
//   - fpga_clk, reset : clock, synchronous active-high reset
//   - inc, dec        : write / read strobes
//   - count           : registered occupancy (0..DEPTH)
//   - count_next      : value count takes at the next edge
//   - rd_blocked      : this cycle's read is a lone read at empty
//   - overflow_flag   : sticky, lone write at DEPTH
//   - underflow_flag  : sticky, lone read at 0
//   Simultaneous inc and dec leave the count untouched, even at the limits.
module bluejay_occupancy_counter
    import bluejay_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int W     = 11
) (
    input  logic         fpga_clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         rd_blocked,
    output logic         overflow_flag,
    output logic         underflow_flag
);

    localparam logic [W-1:0] DEPTH_C = W'(DEPTH);

    logic wr_blocked;

    always_comb begin
        count_next = count;
        rd_blocked = 1'b0;
        wr_blocked = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (count == DEPTH_C) wr_blocked = 1'b1;
                else                  count_next = count + W'(1);
            end
            2'b01: begin
                if (count == '0) rd_blocked = 1'b1;
                else             count_next = count - W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            count          <= '0;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
        end else begin
            count          <= count_next;
            overflow_flag  <= overflow_flag | wr_blocked;
            underflow_flag <= underflow_flag | rd_blocked;
        end
    end

endmodule

// File: rtl/bluejay_line_tracker.sv
// bluejay_line_tracker
//   Tracks dc32 FIFO fill, flags when a full SLM line is buffered, counts
//   consumed lines and runs the end-of-frame buffer-switch handshake.
//   - fpga_clk, reset : clock, synchronous active-high reset
//   - bus (slave)     : write/read strobes, SLM ack, line-available,
//                       update_request, buffer_switch_done
//   - word_count      : FIFO occupancy
//   - line_count      : lines fully consumed in the current frame
//   - overflow_error, underflow_error, protocol_error : sticky error flags
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_STREAM | normal streaming, reads advance word/line tracking
//   ST_REQ    | update_request high, waiting for ack or timeout
//   ST_DONE   | one cycle, buffer_switch_done pulse, back to ST_STREAM
module bluejay_line_tracker
    import bluejay_pkg::*;
#(
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int COUNT_W         = 11,
    parameter int ACK_TIMEOUT     = 4096
) (
    input  logic                   fpga_clk,
    input  logic                   reset,
    bluejay_line_tracker_if.slave  bus,
    output logic [COUNT_W-1:0]     word_count,
    output logic [9:0]             line_count,
    output logic                   overflow_error,
    output logic                   underflow_error,
    output logic                   protocol_error
);

    localparam int WIL_W = (clog2(WORDS_PER_LINE) < 1) ? 1 : clog2(WORDS_PER_LINE);
    localparam int TMO_W = (clog2(ACK_TIMEOUT) < 1) ? 1 : clog2(ACK_TIMEOUT);

    localparam logic [WIL_W-1:0]   WIL_LAST  = WIL_W'(WORDS_PER_LINE - 1);
    localparam logic [9:0]         LINE_LAST = 10'(LINES_PER_FRAME - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [COUNT_W-1:0] WPL_C     = COUNT_W'(WORDS_PER_LINE);

    bluejay_state_e     state_q, state_d;
    logic [WIL_W-1:0]   wil_q, wil_d;
    logic [9:0]         line_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               perr_d;
    logic               ldav_q;
    logic [COUNT_W-1:0] count_next;
    logic               rd_blocked;
    logic               read_ok;

    bluejay_occupancy_counter #(
        .DEPTH (FIFO_DEPTH),
        .W     (COUNT_W)
    ) u_occupancy (
        .fpga_clk       (fpga_clk),
        .reset          (reset),
        .inc            (bus.fifo_write),
        .dec            (bus.get_next_word),
        .count          (word_count),
        .count_next     (count_next),
        .rd_blocked     (rd_blocked),
        .overflow_flag  (overflow_error),
        .underflow_flag (underflow_error)
    );

    // A read at empty never reached the FIFO, so it must not count as a word.
    assign read_ok = bus.get_next_word & ~rd_blocked;

    always_comb begin
        state_d = state_q;
        wil_d   = wil_q;
        line_d  = line_count;
        tmo_d   = '0;
        perr_d  = protocol_error;
        case (state_q)
            ST_STREAM: begin
                if (read_ok) begin
                    if (wil_q == WIL_LAST) begin
                        wil_d = '0;
                        if (line_count == LINE_LAST) begin
                            line_d  = '0;
                            state_d = ST_REQ;
                        end else begin
                            line_d = line_count + 10'd1;
                        end
                    end else begin
                        wil_d = wil_q + WIL_W'(1);
                    end
                end
            end
            ST_REQ: begin
                if (bus.slm_buffer_ack) begin
                    state_d = ST_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    perr_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DONE: state_d = ST_STREAM;
            default: state_d = ST_STREAM;
        endcase
        // The read still drains the FIFO, but bluejay_data should not be
        // pulling words while the SLM buffers are being swapped.
        if (bus.get_next_word && (state_q != ST_STREAM)) perr_d = 1'b1;
    end

    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            state_q        <= ST_STREAM;
            wil_q          <= '0;
            line_count     <= '0;
            tmo_q          <= '0;
            protocol_error <= 1'b0;
            ldav_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wil_q          <= wil_d;
            line_count     <= line_d;
            tmo_q          <= tmo_d;
            protocol_error <= perr_d;
            // Built from next-state values so it drops on the same edge
            // that raises update_request.
            ldav_q         <= (count_next >= WPL_C) && (state_d == ST_STREAM);
        end
    end

    assign bus.line_of_data_available = ldav_q;
    assign bus.update_request         = (state_q == ST_REQ);
    assign bus.buffer_switch_done     = (state_q == ST_DONE);

endmodule
